muldiv_seq: RTL

Sequencer for the ALU's multi-cycle multiply and divide units in the 3-stage RISC-V core. It sits between the EX stage and the ALU.
- Accepts one M-extension op at a time, holds the ALU's op and operands stable, and issues the single-cycle mulstart/divstart pulse.
- Stalls the pipeline, captures the ALU result on mulvalid/divvalid, and returns it with a one-cycle response strobe.
- Returns RISC-V divide-by-zero and signed-overflow results directly, without starting the divider.
- Handles kill (flush) and a watchdog timeout.

---
 rtl/muldiv_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Sequencer between the EX stage and the ALU's multi-cycle multiply/divide units:
// holds operands, pulses start, stalls, returns results, and handles kill and watchdog timeout.
module muldiv_seq #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [6:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        kill,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [6:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        mul_start,
    output logic        div_start,
    input  logic [31:0] alu_out,
    input  logic        mulvalid,
    input  logic        divvalid
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [6:0] OP_NONE = 7'h0F;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_WAIT = 3'd1,
        ST_DIV_WAIT = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    state_t        state_r, state_next_s;
    logic [CW-1:0] cnt_r;
    logic [6:0]    alu_op_r;
    logic [31:0]   alu_a_r, alu_b_r, rsp_data_r;
    logic          rsp_err_r, mul_start_r, div_start_r;
    logic          is_mop_s, accept_s, fast_s, timeout_s, hit_s, waiting_s;
    logic          stall_s, rsp_valid_s;

    // Divide-by-zero and signed-overflow results are architecturally fixed, so no divider run is needed.
    function automatic logic [31:0] fast_result(input logic [6:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [31:0] res;
        if (b == 32'h0000_0000) begin
            res = op[1] ? a : 32'hFFFF_FFFF;
        end else begin
            res = op[1] ? 32'h0000_0000 : 32'h8000_0000;
        end
        return res;
    endfunction

    // Request decode and wait-state event qualifiers.
    always_comb begin
        is_mop_s  = (req_op[6:4] == 3'b001);
        accept_s  = (state_r == ST_IDLE) && req_valid && is_mop_s && !kill;
        fast_s    = !req_op[3] && ((req_b == 32'h0000_0000) ||
                    (!req_op[0] && (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF)));
        timeout_s = (cnt_r == CW'(TIMEOUT - 1));
        waiting_s = (state_r == ST_MUL_WAIT) || (state_r == ST_DIV_WAIT);
        hit_s     = ((state_r == ST_MUL_WAIT) && mulvalid) || ((state_r == ST_DIV_WAIT) && divvalid);
    end

    // State register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; kill beats a same-cycle valid, and valid beats the timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_next_s = ST_IDLE;
                end else if (req_op[3]) begin
                    state_next_s = ST_MUL_WAIT;
                end else if (fast_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_DIV_WAIT;
                end
            end
            ST_MUL_WAIT, ST_DIV_WAIT: begin
                if (kill) begin
                    state_next_s = hit_s ? ST_IDLE : ST_DRAIN;
                end else if (hit_s || timeout_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_DRAIN: begin
                if (mulvalid || divvalid || timeout_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Combinational outputs: stall and the response strobe.
    always_comb begin
        stall_s     = 1'b0;
        rsp_valid_s = 1'b0;
        case (state_r)
            ST_IDLE:     stall_s = accept_s;
            ST_MUL_WAIT: stall_s = 1'b1;
            ST_DIV_WAIT: stall_s = 1'b1;
            ST_DRAIN:    stall_s = req_valid && is_mop_s;
            ST_RESP:     rsp_valid_s = !kill;
            default: begin
                stall_s     = 1'b0;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // Registered datapath: ALU operands, start pulses, watchdog counter and response payload.
    always_ff @(posedge clock) begin
        if (rst) begin
            alu_op_r    <= OP_NONE;
            alu_a_r     <= 32'h0000_0000;
            alu_b_r     <= 32'h0000_0000;
            mul_start_r <= 1'b0;
            div_start_r <= 1'b0;
            cnt_r       <= '0;
            rsp_data_r  <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            mul_start_r <= accept_s && req_op[3];
            div_start_r <= accept_s && !req_op[3] && !fast_s;
            if (accept_s) begin
                alu_op_r <= req_op;
                alu_a_r  <= req_a;
                alu_b_r  <= req_b;
            end
            if ((state_next_s != state_r) || (state_r == ST_IDLE) || (state_r == ST_RESP)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            if (accept_s && fast_s) begin
                rsp_data_r <= fast_result(req_op, req_a, req_b);
                rsp_err_r  <= 1'b0;
            end else if (waiting_s && !kill && hit_s) begin
                rsp_data_r <= alu_out;
                rsp_err_r  <= 1'b0;
            end else if (waiting_s && !kill && timeout_s) begin
                rsp_data_r <= 32'h0000_0000;
                rsp_err_r  <= 1'b1;
            end
        end
    end

    assign stall     = stall_s;
    assign rsp_valid = rsp_valid_s;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;
    assign alu_op    = alu_op_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign mul_start = mul_start_r;
    assign div_start = div_start_r;
endmodule
